// File: rtl/sub_seq_ctrl_if.sv
// sub_seq_ctrl_if: requester-side handshake and result bus of the nibble-serial
// subtraction sequencer. "master" is the requester and "slave" is the sequencer.
interface sub_seq_ctrl_if #(
    parameter int NIBBLES = 4
);
    logic                   start;
    logic [4*NIBBLES-1:0]   op_a;
    logic [4*NIBBLES-1:0]   op_b;
    logic                   borrow_in;
    logic                   busy;
    logic                   done;
    logic [4*NIBBLES-1:0]   diff;
    logic                   borrow_out;
    logic                   zero;
    logic                   ovf;

    modport master (
        output start, op_a, op_b, borrow_in,
        input  busy, done, diff, borrow_out, zero, ovf
    );

    modport slave (
        input  start, op_a, op_b, borrow_in,
        output busy, done, diff, borrow_out, zero, ovf
    );
endinterface

// File: rtl/sub_seq_ctrl.sv
// sub_seq_ctrl: computes A - B - borrow_in over 4*NIBBLES bits by stepping one
// external combinational 4-bit subtractor slice across the operands, least
// significant nibble first, with the borrow chained through a register.
// Optional feature: define SUB_SEQ_OVF_EN to enable signed-overflow reporting
// on ovf. Without it, ovf is tied to 0.
module sub_seq_ctrl #(
    parameter int NIBBLES = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    sub_seq_ctrl_if.slave     req,
    output logic [3:0]        sub_a,
    output logic [3:0]        sub_b,
    output logic              sub_bin,
    input  logic [3:0]        sub_d,
    input  logic              sub_b4
);
    localparam int DATA_W = 4 * NIBBLES;
    localparam int IDX_W  = $clog2(NIBBLES);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t              state;
    logic [IDX_W-1:0]    idx;
    logic [DATA_W-1:0]   a_q;
    logic [DATA_W-1:0]   b_q;
    logic [DATA_W-1:0]   diff_q;
    logic [DATA_W-1:0]   diff_nxt;
    logic                brw_q;
    logic                last_nib;

    // The edge that writes the top nibble is also the edge entering DONE.
    assign last_nib = (state == RUN) && (idx == LAST_IDX);
    assign req.diff = diff_q;

    // Difference with the current slice result merged in; flags on the final
    // edge must see the top nibble that is being written on that same edge.
    always_comb begin
        diff_nxt = diff_q;
        diff_nxt[{idx, 2'b00} +: 4] = sub_d;
    end

    // Slice operands come straight from the latched registers while running;
    // the slice sees zeros otherwise.
    always_comb begin
        sub_a   = 4'd0;
        sub_b   = 4'd0;
        sub_bin = 1'b0;
        if (state == RUN) begin
            sub_a   = a_q[{idx, 2'b00} +: 4];
            sub_b   = b_q[{idx, 2'b00} +: 4];
            sub_bin = brw_q;
        end
    end

    // Sequencer FSM: accept, step one nibble per cycle, pulse done once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state          <= IDLE;
            idx            <= '0;
            a_q            <= '0;
            b_q            <= '0;
            brw_q          <= 1'b0;
            diff_q         <= '0;
            req.busy       <= 1'b0;
            req.done       <= 1'b0;
            req.borrow_out <= 1'b0;
            req.zero       <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    req.done <= 1'b0;
                    if (req.start) begin
                        a_q      <= req.op_a;
                        b_q      <= req.op_b;
                        brw_q    <= req.borrow_in;
                        idx      <= '0;
                        req.busy <= 1'b1;
                        state    <= RUN;
                    end
                end
                RUN: begin
                    diff_q <= diff_nxt;
                    brw_q  <= sub_b4;
                    if (last_nib) begin
                        idx            <= '0;
                        req.done       <= 1'b1;
                        req.borrow_out <= sub_b4;
                        req.zero       <= (diff_nxt == '0);
                        state          <= DONE;
                    end else begin
                        idx <= idx + 1'b1;
                    end
                end
                DONE: begin
                    req.done <= 1'b0;
                    req.busy <= 1'b0;
                    state    <= IDLE;
                end
                default: begin
                    req.done <= 1'b0;
                    req.busy <= 1'b0;
                    state    <= IDLE;
                end
            endcase
        end
    end

`ifdef SUB_SEQ_OVF_EN
    // Signed overflow of a subtraction: operand signs differ and the result
    // sign disagrees with the minuend.
    function automatic logic ovf_calc(input logic a_msb, input logic b_msb,
                                      input logic d_msb);
        return (a_msb != b_msb) && (d_msb != a_msb);
    endfunction

    // Overflow flag captured alongside the other result flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            req.ovf <= 1'b0;
        end else if (last_nib) begin
            req.ovf <= ovf_calc(a_q[DATA_W-1], b_q[DATA_W-1], diff_nxt[DATA_W-1]);
        end
    end
`else
    assign req.ovf = 1'b0;
`endif
endmodule

// File: tb/tb_sub_seq_ctrl.sv
// tb_sub_seq_ctrl: scoreboard bench for sub_seq_ctrl with NIBBLES=4. Stimulus
// pushes expected results computed with whole-word arithmetic; a monitor pops
// and compares whenever done is seen.
module tb_sub_seq_ctrl;
    localparam int N = 4;
    localparam int W = 4 * N;

    typedef struct {
        logic [W-1:0] d;
        logic         b;
        logic         z;
        logic         o;
        int           k;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [3:0] sub_a, sub_b, sub_d;
    logic sub_bin, sub_b4;
    int cyc = 0;
    int n_cmp = 0;
    int n_err = 0;
    exp_t q[$];

    sub_seq_ctrl_if #(.NIBBLES(N)) bus ();

    sub_seq_ctrl #(.NIBBLES(N)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .req     (bus.slave),
        .sub_a   (sub_a),
        .sub_b   (sub_b),
        .sub_bin (sub_bin),
        .sub_d   (sub_d),
        .sub_b4  (sub_b4)
    );

    // External 4-bit ripple subtractor slice.
    assign {sub_b4, sub_d} = {1'b0, sub_a} - {1'b0, sub_b} - {4'd0, sub_bin};

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req_v);
        n_cmp++;
        if (act !== req_v) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, req_v, $time);
        end
    endtask

    // Expected result from whole-word arithmetic.
    function automatic exp_t model(input logic [W-1:0] a, input logic [W-1:0] b,
                                   input logic bin, input int k);
        exp_t e;
        logic [W:0] full;
        full = {1'b0, a} - {1'b0, b} - {{W{1'b0}}, bin};
        e.d = full[W-1:0];
        e.b = full[W];
        e.z = (full[W-1:0] == '0);
`ifdef SUB_SEQ_OVF_EN
        e.o = (a[W-1] != b[W-1]) && (e.d[W-1] != a[W-1]);
`else
        e.o = 1'b0;
`endif
        e.k = k;
        return e;
    endfunction

    // Monitor: every done must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst_n && bus.done) begin
            if (q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL spurious_done: done=1 with no outstanding request (t=%0t)", $time);
            end else begin
                exp_t e;
                e = q.pop_front();
                chk("diff", 32'(bus.diff), 32'(e.d));
                chk("borrow_out", 32'(bus.borrow_out), 32'(e.b));
                chk("zero", 32'(bus.zero), 32'(e.z));
                chk("ovf", 32'(bus.ovf), 32'(e.o));
                chk("busy_at_done", 32'(bus.busy), 32'd1);
                chk("latency", 32'(cyc - e.k), 32'(N));
            end
        end
    end

    task automatic wait_idle();
        int t = 0;
        @(negedge clk);
        while (bus.busy && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (bus.busy) begin
            n_cmp++;
            n_err++;
            $display("FAIL idle_timeout: busy=%0b, expected 0 within 50 cycles", bus.busy);
        end
    endtask

    task automatic issue(input logic [W-1:0] a, input logic [W-1:0] b, input logic bin);
        wait_idle();
        bus.start = 1'b1;
        bus.op_a = a;
        bus.op_b = b;
        bus.borrow_in = bin;
        @(posedge clk);
        #1;
        q.push_back(model(a, b, bin, cyc));
        bus.start = 1'b0;
        bus.op_a = $urandom;
        bus.op_b = $urandom;
        bus.borrow_in = 1'($urandom);
    endtask

    initial begin
        bus.start = 1'b0;
        bus.op_a = '0;
        bus.op_b = '0;
        bus.borrow_in = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 32'(bus.busy), 32'd0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_diff", 32'(bus.diff), 32'd0);
        chk("rst_flags", {29'd0, bus.borrow_out, bus.zero, bus.ovf}, 32'd0);
        chk("rst_slice", {23'd0, sub_a, sub_b, sub_bin}, 32'd0);
        rst_n = 1'b1;

        // Directed cases.
        issue(16'h1234, 16'h0234, 1'b0);
        issue(16'h0000, 16'h0001, 1'b0);
        issue(16'h0005, 16'h0003, 1'b1);
        issue(16'h00FF, 16'h00FF, 1'b0);
        issue(16'h1000, 16'h0001, 1'b0);
        issue(16'h8000, 16'h0001, 1'b0);
        issue(16'h7FFF, 16'hFFFF, 1'b0);

        // Start during RUN is ignored; the in-flight result must be unchanged
        // and no second done may follow.
        issue(16'hBEEF, 16'h1357, 1'b1);
        @(negedge clk);
        @(negedge clk);
        bus.start = 1'b1;
        bus.op_a = 16'h0F0F;
        bus.op_b = 16'hF0F0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_idle();
        repeat (3) @(negedge clk);
        chk("no_queued_start", 32'(q.size()), 32'd0);

        // Back-to-back operations.
        issue(16'h4321, 16'h1234, 1'b0);
        issue(16'hFFFF, 16'hFFFF, 1'b1);

        // Asynchronous reset two cycles into RUN.
        issue(16'hAAAA, 16'h1111, 1'b0);
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("abort_busy", 32'(bus.busy), 32'd0);
        chk("abort_done", 32'(bus.done), 32'd0);
        chk("abort_diff", 32'(bus.diff), 32'd0);
        chk("abort_flags", {29'd0, bus.borrow_out, bus.zero, bus.ovf}, 32'd0);
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        repeat (12) @(negedge clk);
        chk("post_abort_busy", 32'(bus.busy), 32'd0);

        // Randomized operations with occasional idle gaps.
        for (int i = 0; i < 40; i++) begin
            logic [W-1:0] a, b;
            a = W'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : W'($urandom);
            issue(a, b, 1'($urandom_range(0, 1)));
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end

        begin
            int t = 0;
            while (q.size() != 0 && t < 50) begin
                @(negedge clk);
                t++;
            end
            chk("drain", 32'(q.size()), 32'd0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
        $finish;
    end
endmodule
